// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter: turns a fixed-latency (non-FWFT) FIFO read port into
// a valid/ready stream with a small credit-managed skid queue.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   fifo_rd_data      FIFO read data, valid READ_LATENCY clocks after rd_en
//   fifo_rd_en        FIFO read strobe
//   fifo_empty        FIFO empty flag
//   fifo_full         FIFO full flag (informational only)
//   fifo_ready        FIFO out of reset and usable
//   rd_data/rd_valid  stream data and valid
//   rd_ready          stream consumer ready
//   level             current skid queue occupancy
module fifo_stream_adapter #(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2,
    parameter int SKID_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       fifo_rd_data,
    output logic                        fifo_rd_en,
    input  logic                        fifo_empty,
    input  logic                        fifo_full,
    input  logic                        fifo_ready,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [$clog2(SKID_DEPTH):0] level
);

    localparam int PW = $clog2(SKID_DEPTH);
    localparam int LW = PW + 1;
    // Wide enough for level + inflight without overflow.
    localparam int CW = LW + 2;

    logic [READ_LATENCY-1:0] issue_sr;
    logic [READ_LATENCY-1:0] issue_next;
    logic [DATA_WIDTH-1:0]   queue [SKID_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           committed;
    logic                    push;
    logic                    pop;
    logic                    unused_full;

    assign unused_full = fifo_full;

    assign push = issue_sr[READ_LATENCY-1];
    assign pop  = rd_valid & rd_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            if (issue_sr[i]) begin
                inflight = inflight + CW'(1);
            end
        end
    end

    // Slots spoken for next cycle: stored words plus words already
    // requested, less the one leaving now. pop implies level >= 1.
    assign committed = CW'(level) + inflight - CW'(pop);

    assign fifo_rd_en = fifo_ready & ~fifo_empty
                      & (committed < CW'(SKID_DEPTH));

    always_comb begin
        issue_next    = '0;
        issue_next[0] = fifo_rd_en;
        for (int i = 1; i < READ_LATENCY; i++) begin
            issue_next[i] = issue_sr[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_sr <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
        end else begin
            issue_sr <= issue_next;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case (1'b1)
                push & ~pop: level <= level + LW'(1);
                pop & ~push: level <= level - LW'(1);
                default:     level <= level;
            endcase
        end
    end

    // Storage needs no reset: rd_data is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            queue[wr_ptr] <= fifo_rd_data;
        end
    end

    assign rd_valid = (level != '0);
    assign rd_data  = rd_valid ? queue[rd_ptr] : '0;

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !(push && !pop && (level == LW'(SKID_DEPTH)))
    );

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// tb_fifo_stream_adapter: three adapter configurations fed by FIFO models,
// checked with a vector table, a stream scoreboard and corner sequences.
module tb_fifo_stream_adapter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_ready;
    logic       fifo_ready;

    logic [7:0] f_data  [3];
    logic       f_rd_en [3];
    logic       f_empty [3];
    logic [7:0] r_data  [3];
    logic       r_valid [3];
    logic [3:0] lvl     [3];

    int         checks = 0;
    int         errors = 0;
    int         base   = 1;
    int         exp_val   [3];
    logic       hold      [3];
    logic [7:0] hold_data [3];
    int         en_cnt    [3];

    function automatic int rl_of(int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int RL = (g == 0) ? 2 : (g == 1) ? 1 : 3;
        localparam int D  = (g == 1) ? 2 : 4;
        localparam int LW = $clog2(D) + 1;

        logic [7:0]    mem  [256];
        logic [7:0]    pipe [RL];
        int            wcnt;
        int            rcnt;
        logic [LW-1:0] lv;

        assign f_empty[g] = (wcnt == rcnt);
        assign f_data[g]  = pipe[RL-1];
        assign lvl[g]     = 4'(lv);

        always @(posedge clk) begin
            if (rst) begin
                wcnt <= 0;
                rcnt <= 0;
                for (int i = 0; i < RL; i++) pipe[i] <= 8'h00;
            end else begin
                if (wr_en) begin
                    mem[wcnt[7:0]] <= wr_data;
                    wcnt <= wcnt + 1;
                end
                pipe[0] <= f_rd_en[g] ? mem[rcnt[7:0]] : 8'h00;
                for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
                if (f_rd_en[g]) rcnt <= rcnt + 1;
            end
        end

        fifo_stream_adapter #(
            .DATA_WIDTH  (8),
            .READ_LATENCY(RL),
            .SKID_DEPTH  (D)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .fifo_rd_data(f_data[g]),
            .fifo_rd_en  (f_rd_en[g]),
            .fifo_empty  (f_empty[g]),
            .fifo_full   (1'b0),
            .fifo_ready  (fifo_ready),
            .rd_data     (r_data[g]),
            .rd_valid    (r_valid[g]),
            .rd_ready    (rd_ready),
            .level       (lv)
        );
    end

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic sb();
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                exp_val[g] = base;
                hold[g]    = 1'b0;
                en_cnt[g]  = 0;
            end else begin
                if (hold[g]) begin
                    chk("hold_valid", int'(r_valid[g]), 1);
                    chk("hold_data", int'(r_data[g]),
                        int'(hold_data[g]));
                end
                if (f_rd_en[g]) begin
                    en_cnt[g]++;
                    chk("rd_en_on_empty", int'(f_empty[g]), 0);
                end
                if (r_valid[g] && rd_ready) begin
                    chk("order", int'(r_data[g]), exp_val[g] & 255);
                    exp_val[g]++;
                end
                hold[g]      = r_valid[g] & ~rd_ready;
                hold_data[g] = r_data[g];
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        sb();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int wd;
        int rr;
        int lv;
        int v;
        int q;
        int en;
    } vec_t;

    vec_t tab [9];

    initial begin
        tab[0] = '{1, 0, 0, 0, 0, 0};
        tab[1] = '{2, 0, 0, 0, 0, 1};
        tab[2] = '{3, 0, 0, 0, 0, 1};
        tab[3] = '{4, 0, 0, 0, 0, 1};
        tab[4] = '{5, 0, 1, 1, 1, 1};
        tab[5] = '{6, 0, 2, 1, 1, 0};
        tab[6] = '{7, 0, 3, 1, 1, 0};
        tab[7] = '{8, 0, 4, 1, 1, 0};
        tab[8] = '{9, 0, 4, 1, 1, 0};

        wr_en      = 1'b0;
        wr_data    = 8'h00;
        rd_ready   = 1'b0;
        fifo_ready = 1'b1;
        rst        = 1'b1;
        base       = 1;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_level", int'(lvl[0]), 0);
        chk("rst_valid", int'(r_valid[0]), 0);
        chk("rst_rd_en", int'(f_rd_en[0]), 0);
        chk("rst_data", int'(r_data[0]), 0);
        sb();
        @(posedge clk);
        #1;

        // Fill with rd_ready low.
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            wr_en    = 1'b1;
            wr_data  = 8'(tab[k].wd);
            rd_ready = tab[k].rr[0];
            @(negedge clk);
            chk("t1_level", int'(lvl[0]), tab[k].lv);
            chk("t1_valid", int'(r_valid[0]), tab[k].v);
            chk("t1_data", int'(r_data[0]), tab[k].q);
            chk("t1_rd_en", int'(f_rd_en[0]), tab[k].en);
            sb();
            @(posedge clk);
            #1;
        end
        for (int k = 9; k < 127; k++) begin
            wr_data = 8'(k + 1);
            cyc();
        end
        wr_en = 1'b0;
        @(negedge clk);
        chk("full_level0", int'(lvl[0]), 4);
        chk("full_level1", int'(lvl[1]), 2);
        chk("full_level2", int'(lvl[2]), 4);
        chk("full_rd_en0", int'(f_rd_en[0]), 0);
        chk("full_data0", int'(r_data[0]), 1);
        sb();
        @(posedge clk);
        #1;

        // Stream with rd_ready held high: one word per clock.
        rd_ready = 1'b1;
        for (int n = 0; n < 123; n++) cyc();
        for (int g = 0; g < 3; g++) chk("burst_count", exp_val[g], 124);

        // Random backpressure while the rest drains.
        for (int n = 0; n < 600; n++) begin
            if (exp_val[0] == 128 && exp_val[1] == 128 &&
                exp_val[2] == 128) break;
            rd_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        for (int g = 0; g < 3; g++) chk("drain_count", exp_val[g], 128);

        // Single word latency.
        rd_ready = 1'b1;
        rst      = 1'b1;
        base     = 8'h5A;
        cyc();
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wr_en   = (k == 0);
            wr_data = 8'h5A;
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                chk("single_valid", int'(r_valid[g]),
                    int'(k == rl_of(g) + 2));
                chk("single_rd_en", int'(f_rd_en[g]), int'(k == 1));
            end
            sb();
            @(posedge clk);
            #1;
        end
        for (int g = 0; g < 3; g++) begin
            chk("single_en_cnt", en_cnt[g], 1);
            chk("single_rx", exp_val[g], 8'h5B);
        end

        // Reset while words are queued and in flight.
        rd_ready = 1'b0;
        rst      = 1'b1;
        base     = 1;
        cyc();
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'(k + 1);
            cyc();
        end
        @(negedge clk);
        chk("pre_rst_level", int'(lvl[0]), 3);
        sb();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rst   = 1'b1;
        base  = 200;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("post_rst_level", int'(lvl[g]), 0);
            chk("post_rst_valid", int'(r_valid[g]), 0);
            chk("post_rst_rd_en", int'(f_rd_en[g]), 0);
        end
        sb();
        @(posedge clk);
        #1;
        rd_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'(200 + k);
            cyc();
        end
        wr_en = 1'b0;
        for (int k = 0; k < 20; k++) cyc();
        for (int g = 0; g < 3; g++) chk("refill_rx", exp_val[g], 210);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
